// File: rtl/invz_bus_driver_ctrl.sv
// Sequencer for a bank of invz_16 tristate inverters on a shared bus.
// Pre-inverts accepted words and runs setup -> drive -> turnoff around the invz EN pins.
module invz_bus_driver_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned DRIVE_CYC = 2,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic             CLK,
  input  logic             RN,
  inout  wire              VDD,
  inout  wire              VSS,
  input  logic             GNT,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] REQ_DATA,
  input  logic             REQ_LAST,
  output logic             EN,
  output logic [WIDTH-1:0] I,
  output logic             BUSY,
  output logic             ABORT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DRIVE,
    S_TURNOFF
  } state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC);
  localparam logic [3:0] DRIVE_LD = 4'(DRIVE_CYC);
  localparam logic [3:0] GAP_LD   = 4'(GAP_CYC);

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic             last, last_n;
  logic [WIDTH-1:0] i_n;
  logic             en_n, busy_n, abort_n;
  logic             fire, cnt_one, gnt_lost;

  // Rails exist only so the block drops in beside the cells; no logic uses them.
  logic unused_rails;
  assign unused_rails = VDD ^ VSS;

  assign cnt_one  = (cnt == 4'd1);
  assign gnt_lost = ~GNT & ((state == S_SETUP) | (state == S_DRIVE));
  assign fire     = REQ_VALID & REQ_READY;

  always_comb begin
    REQ_READY = 1'b0;
    case (state)
      S_IDLE:  REQ_READY = GNT;
      S_DRIVE: REQ_READY = GNT & cnt_one & ~last;
      default: REQ_READY = 1'b0;
    endcase
    REQ_READY = REQ_READY & RN;
  end

  // State register, including the registered outputs.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state <= S_IDLE;
      cnt   <= '0;
      last  <= 1'b0;
      EN    <= 1'b0;
      I     <= '0;
      BUSY  <= 1'b0;
      ABORT <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
      EN    <= en_n;
      I     <= i_n;
      BUSY  <= busy_n;
      ABORT <= abort_n;
    end
  end

  // Next-state logic; grant loss takes priority over the counter exit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (fire) begin
          state_n = S_SETUP;
          cnt_n   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (gnt_lost) begin
          state_n = S_TURNOFF;
          cnt_n   = GAP_LD;
        end else if (cnt_one) begin
          state_n = S_DRIVE;
          cnt_n   = DRIVE_LD;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_DRIVE: begin
        if (gnt_lost) begin
          state_n = S_TURNOFF;
          cnt_n   = GAP_LD;
        end else if (cnt_one) begin
          if (fire) begin
            cnt_n = DRIVE_LD;
          end else begin
            state_n = S_TURNOFF;
            cnt_n   = GAP_LD;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_TURNOFF: begin
        cnt_n = cnt - 4'd1;
        if (cnt_one) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output logic: outputs are registered from the next state so EN tracks DRIVE exactly.
  always_comb begin
    en_n    = (state_n == S_DRIVE);
    busy_n  = (state_n != S_IDLE);
    abort_n = gnt_lost;
    i_n     = I;
    last_n  = last;
    if (fire) begin
      i_n    = ~REQ_DATA;
      last_n = REQ_LAST;
    end
  end

endmodule

// File: tb/tb_invz_bus_driver_ctrl.sv
// Directed bench for invz_bus_driver_ctrl: default timing instance plus a 3/4/2 instance.
module tb_invz_bus_driver_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn, gnt;
  logic       v1, l1, rdy1, en1, busy1, ab1;
  logic [7:0] d1, i1;
  logic       v2, l2, rdy2, en2, busy2, ab2;
  logic [7:0] d2, i2;
  wire        vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  invz_bus_driver_ctrl #(.WIDTH(8), .SETUP_CYC(1), .DRIVE_CYC(2), .GAP_CYC(1)) u_dut1 (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .GNT(gnt),
    .REQ_VALID(v1), .REQ_READY(rdy1), .REQ_DATA(d1), .REQ_LAST(l1),
    .EN(en1), .I(i1), .BUSY(busy1), .ABORT(ab1)
  );

  invz_bus_driver_ctrl #(.WIDTH(8), .SETUP_CYC(3), .DRIVE_CYC(4), .GAP_CYC(2)) u_dut2 (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .GNT(gnt),
    .REQ_VALID(v2), .REQ_READY(rdy2), .REQ_DATA(d2), .REQ_LAST(l2),
    .EN(en2), .I(i2), .BUSY(busy2), .ABORT(ab2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ck1(input string tag, input logic en, input logic busy, input logic abort);
    check({tag, "_en"},    32'(en1),   32'(en));
    check({tag, "_busy"},  32'(busy1), 32'(busy));
    check({tag, "_abort"}, 32'(ab1),   32'(abort));
  endtask

  // EN must only rise once I has already settled for at least one cycle.
  logic       en1_q = 1'b0, en2_q = 1'b0;
  logic [7:0] i1_q = '0, i2_q = '0;
  always @(negedge clk) begin
    if (en1 === 1'b1 && en1_q === 1'b0) check("d1_en_rise_i_stable", 32'(i1), 32'(i1_q));
    if (en2 === 1'b1 && en2_q === 1'b0) check("d2_en_rise_i_stable", 32'(i2), 32'(i2_q));
    en1_q = en1;
    en2_q = en2;
    i1_q  = i1;
    i2_q  = i2;
  end

  logic exp_en2 [1:10];
  logic exp_bz2 [1:10];

  initial begin
    rn = 1'b0; gnt = 1'b1;
    v1 = 1'b1; d1 = 8'hFF; l1 = 1'b0;
    v2 = 1'b0; d2 = 8'h00; l2 = 1'b0;

    // Reset
    @(negedge clk);
    check("rst_ready_gated", 32'(rdy1), 32'd0);
    step(); step();
    ck1("rst", 1'b0, 1'b0, 1'b0);
    check("rst_i", 32'(i1), 32'h00);
    check("rst_ready", 32'(rdy1), 32'd0);
    rn = 1'b1; v1 = 1'b0;
    step();
    check("idle_ready", 32'(rdy1), 32'd1);

    // Single word A5
    v1 = 1'b1; d1 = 8'hA5; l1 = 1'b1;
    check("w1_ready_t0", 32'(rdy1), 32'd1);
    step(); v1 = 1'b0;
    ck1("w1_t1", 1'b0, 1'b1, 1'b0);
    check("w1_i_t1", 32'(i1), 32'h5A);
    check("w1_ready_t1", 32'(rdy1), 32'd0);
    step(); ck1("w1_t2", 1'b1, 1'b1, 1'b0);
    step(); ck1("w1_t3", 1'b1, 1'b1, 1'b0);
    step(); ck1("w1_t4", 1'b0, 1'b1, 1'b0);
    check("w1_i_hold_t4", 32'(i1), 32'h5A);
    step(); ck1("w1_t5", 1'b0, 1'b0, 1'b0);
    check("w1_ready_t5", 32'(rdy1), 32'd1);

    // Burst 01,02,03 with VALID held
    v1 = 1'b1; d1 = 8'h01; l1 = 1'b0;
    step(); d1 = 8'h02;
    ck1("b_t1", 1'b0, 1'b1, 1'b0);
    check("b_i_t1", 32'(i1), 32'hFE);
    check("b_ready_t1", 32'(rdy1), 32'd0);
    step(); ck1("b_t2", 1'b1, 1'b1, 1'b0);
    check("b_ready_t2", 32'(rdy1), 32'd0);
    step(); ck1("b_t3", 1'b1, 1'b1, 1'b0);
    check("b_ready_t3", 32'(rdy1), 32'd1);
    check("b_i_t3", 32'(i1), 32'hFE);
    step(); d1 = 8'h03; l1 = 1'b1;
    ck1("b_t4", 1'b1, 1'b1, 1'b0);
    check("b_i_t4", 32'(i1), 32'hFD);
    check("b_ready_t4", 32'(rdy1), 32'd0);
    step(); ck1("b_t5", 1'b1, 1'b1, 1'b0);
    check("b_ready_t5", 32'(rdy1), 32'd1);
    step(); v1 = 1'b0;
    ck1("b_t6", 1'b1, 1'b1, 1'b0);
    check("b_i_t6", 32'(i1), 32'hFC);
    step(); ck1("b_t7", 1'b1, 1'b1, 1'b0);
    check("b_ready_t7_last", 32'(rdy1), 32'd0);
    step(); ck1("b_t8", 1'b0, 1'b1, 1'b0);
    step(); ck1("b_t9", 1'b0, 1'b0, 1'b0);

    // Burst with a bubble
    v1 = 1'b1; d1 = 8'h10; l1 = 1'b0;
    step(); v1 = 1'b0;
    ck1("bb_t1", 1'b0, 1'b1, 1'b0);
    step(); ck1("bb_t2", 1'b1, 1'b1, 1'b0);
    step(); ck1("bb_t3", 1'b1, 1'b1, 1'b0);
    check("bb_ready_t3", 32'(rdy1), 32'd1);
    step(); v1 = 1'b1; d1 = 8'h20; l1 = 1'b1;
    ck1("bb_t4", 1'b0, 1'b1, 1'b0);
    check("bb_i_t4", 32'(i1), 32'hEF);
    check("bb_ready_t4", 32'(rdy1), 32'd0);
    step(); ck1("bb_t5", 1'b0, 1'b0, 1'b0);
    check("bb_ready_t5", 32'(rdy1), 32'd1);
    step(); v1 = 1'b0;
    ck1("bb_t6", 1'b0, 1'b1, 1'b0);
    check("bb_i_t6", 32'(i1), 32'hDF);
    step(); ck1("bb_t7", 1'b1, 1'b1, 1'b0);
    step(); step(); step();
    ck1("bb_t10", 1'b0, 1'b0, 1'b0);

    // Grant drop in the second DRIVE cycle
    v1 = 1'b1; d1 = 8'h33; l1 = 1'b1;
    step(); v1 = 1'b0;
    step(); ck1("g_t2", 1'b1, 1'b1, 1'b0);
    step(); gnt = 1'b0;
    ck1("g_t3", 1'b1, 1'b1, 1'b0);
    check("g_ready_t3", 32'(rdy1), 32'd0);
    step(); ck1("g_t4", 1'b0, 1'b1, 1'b1);
    check("g_i_t4", 32'(i1), 32'hCC);
    step(); ck1("g_t5", 1'b0, 1'b0, 1'b0);
    v1 = 1'b1; d1 = 8'h44;
    check("g_ready_idle_nognt", 32'(rdy1), 32'd0);
    step(); ck1("g_t6", 1'b0, 1'b0, 1'b0);
    check("g_i_t6", 32'(i1), 32'hCC);
    gnt = 1'b1; v1 = 1'b0;
    step();

    // Reset asserted mid-DRIVE
    v1 = 1'b1; d1 = 8'hA5; l1 = 1'b1;
    step(); v1 = 1'b0;
    step(); rn = 1'b0;
    ck1("r_t2", 1'b1, 1'b1, 1'b0);
    check("r_ready_rn_low", 32'(rdy1), 32'd0);
    step(); rn = 1'b1;
    ck1("r_t3", 1'b0, 1'b0, 1'b0);
    check("r_i_t3", 32'(i1), 32'h00);
    step();
    v1 = 1'b1; d1 = 8'hC3; l1 = 1'b1;
    check("r_ready_resume", 32'(rdy1), 32'd1);
    step(); v1 = 1'b0;
    check("r_i_resume", 32'(i1), 32'h3C);
    step(); ck1("r_resume_drive", 1'b1, 1'b1, 1'b0);
    step(); step(); step();

    // 3/4/2 instance
    exp_en2 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_bz2 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    v2 = 1'b1; d2 = 8'h7E; l2 = 1'b1;
    check("p2_ready_t0", 32'(rdy2), 32'd1);
    step(); v2 = 1'b0;
    check("p2_i_t1", 32'(i2), 32'h81);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("p2_en_t%0d", k),   32'(en2),   32'(exp_en2[k]));
      check($sformatf("p2_busy_t%0d", k), 32'(busy2), 32'(exp_bz2[k]));
      if (k < 10) step();
    end
    check("p2_ready_idle", 32'(rdy2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
